radiant_scaler_readout: RTL and testbench

Sequencer that drains the scaler bank once per scaler update. On each update pulse it emits a header word, then performs NWORDS single WISHBONE reads of the dual-packed scaler words starting at the scaler readback window. Each word is forwarded on a valid/ready stream toward the event/housekeeping formatter. It sits between the scaler slave, as its WISHBONE master, and the output formatter. It owns frame sequencing, drops and bus-fault substitution.

---
 rtl/radiant_scaler_pkg.sv | 18 +
 rtl/radiant_scaler_readout_if.sv | 29 ++
 rtl/wb_single_read.sv | 55 +++++
 rtl/radiant_scaler_readout.sv | 131 +++++++++++++
 tb/tb_radiant_scaler_readout.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/radiant_scaler_pkg.sv
// Shared constants for the scaler readout sequencer: FSM encoding, header magic,
// the substituted word for failed reads and the default readback window.
package radiant_scaler_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_READ = 2'd2;
  localparam logic [1:0] ST_PUSH = 2'd3;

  localparam logic [7:0]  HDR_MAGIC    = 8'hA5;
  localparam logic [31:0] FAULT_WORD   = 32'hFFFF_FFFF;
  localparam logic [15:0] DEF_BASE_ADR = 16'h0800;

  function automatic logic [15:0] word_adr(input logic [15:0] base, input logic [6:0] idx);
    return base + {7'b0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/radiant_scaler_readout_if.sv
// WISHBONE classic master port plus the outgoing valid/ready word stream.
interface radiant_scaler_readout_if;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [15:0] wbm_adr_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        wbm_err_i;
  logic [31:0] m_tdata_o;
  logic        m_tvalid_o;
  logic        m_tlast_o;
  logic        m_tready_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_sel_o,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i,
    output m_tdata_o, m_tvalid_o, m_tlast_o,
    input  m_tready_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_sel_o,
    output wbm_dat_i, wbm_ack_i, wbm_err_i,
    input  m_tdata_o, m_tvalid_o, m_tlast_o,
    output m_tready_i
  );
endinterface

// File: rtl/wb_single_read.sv
// One WISHBONE classic read with watchdog: cyc rises the cycle after start_i and
// drops the cycle after ack, err or TIMEOUT idle cycles; done_o is combinational.
module wb_single_read
  import radiant_scaler_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [15:0] adr_i,
  output logic        done_o,
  output logic [31:0] data_o,
  output logic        fault_o,
  output logic        cyc_o,
  output logic [15:0] adr_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i,
  input  logic        err_i
);

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  logic        r_cyc;
  logic [15:0] r_adr;
  logic [7:0]  r_cnt;
  logic        w_ack_ok;
  logic        w_timeout;

  // A real termination in the watchdog's final cycle is still honoured.
  assign w_ack_ok  = r_cyc && ack_i && !err_i;
  assign w_timeout = r_cyc && !ack_i && !err_i && (r_cnt == TO_LIM);
  assign done_o    = (r_cyc && (ack_i || err_i)) || w_timeout;
  assign data_o    = w_ack_ok ? dat_i : FAULT_WORD;
  assign fault_o   = done_o && !w_ack_ok;
  assign cyc_o     = r_cyc;
  assign adr_o     = r_adr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cyc <= 1'b0;
      r_adr <= 16'h0;
      r_cnt <= 8'h0;
    end else if (start_i) begin
      r_cyc <= 1'b1;
      r_adr <= adr_i;
      r_cnt <= 8'h0;
    end else if (done_o) begin
      r_cyc <= 1'b0;
    end else if (r_cyc) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/radiant_scaler_readout.sv
// Drains the scaler bank per update: header word, then nwords single reads streamed out.
// Header valid one cycle after update; stream words held stable while m_tready_i is low.
module radiant_scaler_readout
  import radiant_scaler_pkg::*;
#(
  parameter int          NUM_WORDS = 32,
  parameter logic [15:0] BASE_ADR  = DEF_BASE_ADR,
  parameter int          TIMEOUT   = 255
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            enable_i,
  input  logic                            update_i,
  input  logic [6:0]                      nwords_i,
  radiant_scaler_readout_if.master        bus,
  output logic                            busy_o,
  output logic [15:0]                     seq_o,
  output logic [7:0]                      drop_cnt_o,
  output logic                            fault_o
);

  localparam logic [6:0] NW_MAX = 7'(NUM_WORDS);

  logic [1:0]  r_state;
  logic [15:0] r_seq;
  logic [6:0]  r_nwords;
  logic [6:0]  r_idx;
  logic [31:0] r_word;
  logic [7:0]  r_drop;
  logic        r_fault;

  logic [6:0]  w_nw_clamp;
  logic        w_hs;
  logic        w_last;
  logic        w_start;
  logic [6:0]  w_next_idx;
  logic        w_drop;
  logic        w_rd_done;
  logic [31:0] w_rd_data;
  logic        w_rd_fault;
  logic        w_cyc;
  logic [15:0] w_adr;

  assign w_nw_clamp = (nwords_i > NW_MAX) ? NW_MAX : nwords_i;
  assign w_hs       = bus.m_tvalid_o && bus.m_tready_i;
  assign w_last     = (r_idx == r_nwords - 7'd1);
  assign w_next_idx = (r_state == ST_HDR) ? 7'd0 : r_idx + 7'd1;
  assign w_start    = w_hs && (((r_state == ST_HDR) && (r_nwords != 7'd0)) ||
                               ((r_state == ST_PUSH) && !w_last));
  // Any update that cannot open a frame is counted, including the final-handshake cycle.
  assign w_drop     = update_i && ((r_state != ST_IDLE) || !enable_i);

  wb_single_read #(.TIMEOUT(TIMEOUT)) u_rd (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (w_start),
    .adr_i   (word_adr(BASE_ADR, w_next_idx)),
    .done_o  (w_rd_done),
    .data_o  (w_rd_data),
    .fault_o (w_rd_fault),
    .cyc_o   (w_cyc),
    .adr_o   (w_adr),
    .dat_i   (bus.wbm_dat_i),
    .ack_i   (bus.wbm_ack_i),
    .err_i   (bus.wbm_err_i)
  );

  assign bus.wbm_cyc_o  = w_cyc;
  assign bus.wbm_stb_o  = w_cyc;
  assign bus.wbm_we_o   = 1'b0;
  assign bus.wbm_adr_o  = w_adr;
  assign bus.wbm_sel_o  = 4'hF;

  assign bus.m_tvalid_o = (r_state == ST_HDR) || (r_state == ST_PUSH);
  assign bus.m_tdata_o  = (r_state == ST_HDR) ? {HDR_MAGIC, 1'b0, r_nwords, r_seq} : r_word;
  assign bus.m_tlast_o  = ((r_state == ST_HDR) && (r_nwords == 7'd0)) ||
                          ((r_state == ST_PUSH) && w_last);

  assign busy_o     = (r_state != ST_IDLE);
  assign seq_o      = r_seq;
  assign drop_cnt_o = r_drop;
  assign fault_o    = r_fault;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= ST_IDLE;
      r_seq    <= 16'h0;
      r_nwords <= 7'h0;
      r_idx    <= 7'h0;
      r_word   <= 32'h0;
      r_fault  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (update_i && enable_i) begin
            r_seq    <= r_seq + 16'd1;
            r_nwords <= w_nw_clamp;
            r_idx    <= 7'h0;
            r_state  <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (w_hs) r_state <= (r_nwords == 7'd0) ? ST_IDLE : ST_READ;
        end
        ST_READ: begin
          if (w_rd_done) begin
            r_word  <= w_rd_data;
            r_state <= ST_PUSH;
            if (w_rd_fault) r_fault <= 1'b1;
          end
        end
        default: begin
          if (w_hs) begin
            if (w_last) begin
              r_state <= ST_IDLE;
            end else begin
              r_idx   <= r_idx + 7'd1;
              r_state <= ST_READ;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                        r_drop <= 8'h0;
    else if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
  end

endmodule

// File: tb/tb_radiant_scaler_readout.sv
// Directed bench for radiant_scaler_readout: table of frames against a WISHBONE slave
// model, plus hand sequences for disabled updates, drop saturation and mid-read reset.
module tb_radiant_scaler_readout;
  import radiant_scaler_pkg::*;

  typedef struct {
    logic [6:0]  nwords;
    int          dly;
    int          bp;
    int          bad_idx;
    int          bad_mode;
    logic [31:0] exp_hdr;
    int          exp_n;
    logic        exp_fault;
  } vec_t;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        enable_i = 1'b0;
  logic        update_i = 1'b0;
  logic [6:0]  nwords_i = 7'd0;
  logic        busy_o;
  logic [15:0] seq_o;
  logic [7:0]  drop_cnt_o;
  logic        fault_o;

  logic        sl_ack = 1'b0;
  logic        sl_err = 1'b0;
  logic [31:0] sl_dat = 32'h0;
  logic        tready = 1'b0;

  int          sl_dly = 0;
  int          sl_bad = -1;
  int          sl_mode = 0;
  int          sl_rd = 0;
  int          sl_base = 0;
  int          sl_age = 0;
  int          sl_bad_len = 0;
  int          sl_attr_err = 0;
  logic [15:0] sl_adrs[$];

  int total = 0;
  int bad = 0;

  radiant_scaler_readout_if bus();

  assign bus.wbm_ack_i  = sl_ack;
  assign bus.wbm_err_i  = sl_err;
  assign bus.wbm_dat_i  = sl_dat;
  assign bus.m_tready_i = tready;

  radiant_scaler_readout #(.NUM_WORDS(32), .BASE_ADR(16'h0800), .TIMEOUT(255)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .enable_i   (enable_i),
    .update_i   (update_i),
    .nwords_i   (nwords_i),
    .bus        (bus.master),
    .busy_o     (busy_o),
    .seq_o      (seq_o),
    .drop_cnt_o (drop_cnt_o),
    .fault_o    (fault_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] sl_data(input logic [15:0] a);
    return {~a, a} ^ 32'h1234_5678;
  endfunction

  // Slave model: acks sl_dly cycles after cyc rises; the bad read gets ack+err or silence.
  always @(negedge clk_i) begin
    if (bus.wbm_cyc_o && bus.wbm_stb_o) begin
      if (sl_age == 0) begin
        sl_adrs.push_back(bus.wbm_adr_o);
        if (bus.wbm_we_o || bus.wbm_sel_o != 4'hF) sl_attr_err++;
      end
      if (sl_age == sl_dly && !((sl_rd - sl_base) == sl_bad && sl_mode == 1)) begin
        sl_ack = 1'b1;
        sl_err = ((sl_rd - sl_base) == sl_bad);
        sl_dat = sl_data(bus.wbm_adr_o);
      end else begin
        sl_ack = 1'b0;
        sl_err = 1'b0;
      end
      sl_age++;
    end else begin
      if (sl_age > 0) begin
        if ((sl_rd - sl_base) == sl_bad) sl_bad_len = sl_age;
        sl_rd++;
      end
      sl_age = 0;
      sl_ack = 1'b0;
      sl_err = 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_frame(input vec_t v, input int pulse_per, output int pulses);
    logic [31:0] rx[$];
    int          stall = 0;
    int          stab_err = 0;
    int          cyc = 0;
    int          abase;
    bit          prev_stall = 0;
    bit          done = 0;
    logic [31:0] pd = 32'h0;
    logic        pl = 1'b0;
    logic [31:0] exp;
    pulses  = 0;
    abase   = sl_adrs.size();
    sl_base = sl_rd;
    sl_dly  = v.dly;
    sl_bad  = v.bad_idx;
    sl_mode = v.bad_mode;
    @(negedge clk_i);
    nwords_i = v.nwords;
    update_i = 1'b1;
    tready   = (v.bp == 0);
    @(negedge clk_i);
    update_i = 1'b0;
    chk("hdr_latency", {31'b0, bus.m_tvalid_o}, 32'd1);
    while (!done && cyc < 20000) begin
      update_i = (pulse_per > 0 && cyc > 0 && (cyc % pulse_per) == 0);
      if (update_i) pulses++;
      if (prev_stall && (!bus.m_tvalid_o || bus.m_tdata_o !== pd || bus.m_tlast_o !== pl))
        stab_err++;
      prev_stall = 0;
      if (bus.m_tvalid_o) begin
        if (stall < v.bp) begin
          tready = 1'b0;
          stall++;
          prev_stall = 1;
          pd = bus.m_tdata_o;
          pl = bus.m_tlast_o;
          if (bus.wbm_cyc_o) stab_err++;
        end else begin
          tready = 1'b1;
          stall  = 0;
          rx.push_back(bus.m_tdata_o);
          done = bus.m_tlast_o;
        end
      end else begin
        tready = (v.bp == 0);
      end
      cyc++;
      @(negedge clk_i);
    end
    update_i = 1'b0;
    chk("frame_end", {31'b0, done}, 32'd1);
    chk("busy_after", {31'b0, busy_o}, 32'd0);
    chk("word_count", rx.size(), v.exp_n + 1);
    if (rx.size() > 0) chk("header", rx[0], v.exp_hdr);
    for (int k = 1; k < rx.size(); k++) begin
      exp = ((k - 1) == v.bad_idx) ? FAULT_WORD : sl_data(16'h0800 + 16'(4 * (k - 1)));
      chk("data", rx[k], exp);
    end
    chk("wb_reads", sl_adrs.size() - abase, v.exp_n);
    for (int k = 0; k < v.exp_n && (abase + k) < sl_adrs.size(); k++)
      chk("wb_adr", {16'h0, sl_adrs[abase + k]}, 32'h0800 + 32'(4 * k));
    chk("stable", stab_err, 0);
    chk("fault", {31'b0, fault_o}, {31'b0, v.exp_fault});
    chk("seq", {16'h0, seq_o}, {16'h0, v.exp_hdr[15:0]});
  endtask

  vec_t vecs[8];
  vec_t vdrop;
  vec_t vpost;

  initial begin
    int p;
    int exp_drop;
    vecs[0] = '{7'd4,   2, 0,  -1, 0, 32'hA504_0001, 4,  1'b0};
    vecs[1] = '{7'd4,   2, 10, -1, 0, 32'hA504_0002, 4,  1'b0};
    vecs[2] = '{7'd0,   1, 0,  -1, 0, 32'hA500_0003, 0,  1'b0};
    vecs[3] = '{7'd100, 0, 0,  -1, 0, 32'hA520_0004, 32, 1'b0};
    vecs[4] = '{7'd64,  1, 0,  -1, 0, 32'hA520_0005, 32, 1'b0};
    vecs[5] = '{7'd1,   3, 3,  -1, 0, 32'hA501_0006, 1,  1'b0};
    vecs[6] = '{7'd5,   1, 0,  2,  0, 32'hA505_0007, 5,  1'b1};
    vecs[7] = '{7'd4,   1, 0,  2,  1, 32'hA504_0008, 4,  1'b1};
    vdrop   = '{7'd32, 40, 0,  -1, 0, 32'hA520_0009, 32, 1'b1};
    vpost   = '{7'd2,   1, 0,  -1, 0, 32'hA502_0001, 2,  1'b0};

    repeat (3) @(negedge clk_i);
    chk("rst_seq", {16'h0, seq_o}, 32'h0);
    chk("rst_drop", {24'h0, drop_cnt_o}, 32'h0);
    chk("rst_valid", {31'b0, bus.m_tvalid_o}, 32'h0);
    chk("rst_cyc", {31'b0, bus.wbm_cyc_o}, 32'h0);
    rst_ni   = 1'b1;
    enable_i = 1'b1;
    @(negedge clk_i);
    chk("idle_busy", {31'b0, busy_o}, 32'h0);
    chk("idle_fault", {31'b0, fault_o}, 32'h0);

    for (int i = 0; i < 8; i++) begin
      run_frame(vecs[i], 0, p);
      if (vecs[i].bad_mode == 1) chk("timeout_len", sl_bad_len, 256);
    end
    chk("wb_attr", sl_attr_err, 0);

    // Update while disabled: no frame, one drop.
    enable_i = 1'b0;
    update_i = 1'b1;
    @(negedge clk_i);
    update_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("dis_busy", {31'b0, busy_o}, 32'h0);
    chk("dis_valid", {31'b0, bus.m_tvalid_o}, 32'h0);
    chk("dis_drop", {24'h0, drop_cnt_o}, 32'd1);
    enable_i = 1'b1;

    // Pulses every 5 cycles through a long frame saturate the drop counter.
    run_frame(vdrop, 5, p);
    exp_drop = (1 + p > 255) ? 255 : 1 + p;
    chk("drop_sat", {24'h0, drop_cnt_o}, 32'(exp_drop));

    // Asynchronous reset in the middle of a read.
    sl_base = sl_rd;
    sl_dly  = 50;
    sl_bad  = -1;
    nwords_i = 7'd8;
    update_i = 1'b1;
    tready   = 1'b1;
    @(negedge clk_i);
    update_i = 1'b0;
    for (int i = 0; i < 20 && !bus.wbm_cyc_o; i++) @(negedge clk_i);
    chk("mid_cyc_seen", {31'b0, bus.wbm_cyc_o}, 32'd1);
    repeat (3) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    chk("ar_cyc", {31'b0, bus.wbm_cyc_o}, 32'h0);
    chk("ar_stb", {31'b0, bus.wbm_stb_o}, 32'h0);
    chk("ar_valid", {31'b0, bus.m_tvalid_o}, 32'h0);
    chk("ar_busy", {31'b0, busy_o}, 32'h0);
    chk("ar_seq", {16'h0, seq_o}, 32'h0);
    chk("ar_drop", {24'h0, drop_cnt_o}, 32'h0);
    chk("ar_fault", {31'b0, fault_o}, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    run_frame(vpost, 0, p);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
